csr_seq_ctrl: RTL and testbench

//  Multi-cycle sequencer in front of the single-port machine-mode CSR file. Accepts one CSR op from EXU
//  (CSRRW/CSRRS/CSRRC/ECALL/MRET) via valid/ready, issues ordered read/write cycles on the CSR port
//  (one access per cycle), returns old CSR value for rd, and emits a PC redirect for trap entry/return.

---
 rtl/csr_pkg.sv | 31 +++
 rtl/csr_rmw_alu.sv | 39 +++
 rtl/csr_seq_ctrl.sv | 147 ++++++++++++++
 tb/tb_csr_seq_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared types and CSR constants for the machine-mode CSR sequencer.
package csr_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_CSRRW = 3'd1,
        OP_CSRRS = 3'd2,
        OP_CSRRC = 3'd3,
        OP_ECALL = 3'd4,
        OP_MRET  = 3'd5
    } csr_op_e;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_RD    = 4'd1,
        ST_WR    = 4'd2,
        ST_EPC   = 4'd3,
        ST_CAUSE = 4'd4,
        ST_STAT  = 4'd5,
        ST_VEC   = 4'd6,
        ST_MRD   = 4'd7,
        ST_DONE  = 4'd8
    } seq_state_e;

    localparam logic [11:0] CSR_MSTATUS    = 12'h300;
    localparam logic [11:0] CSR_MTVEC      = 12'h305;
    localparam logic [11:0] CSR_MEPC       = 12'h341;
    localparam logic [11:0] CSR_MCAUSE     = 12'h342;
    localparam int          MCAUSE_ECALL_M = 11;

endpackage

// File: rtl/csr_rmw_alu.sv
// Read-modify-write data path for CSRRW/CSRRS/CSRRC; decides whether the write is issued.
module csr_rmw_alu
    import csr_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  csr_op_e            op,
    input  logic [WIDTH-1:0]   old,
    input  logic [WIDTH-1:0]   src,
    output logic [WIDTH-1:0]   wdata,
    output logic               do_write
);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        wdata    = old;
        do_write = 1'b0;
        case (op)
            OP_CSRRW: begin
                wdata    = src;
                do_write = 1'b1;
            end
            // Set/clear with a zero mask must not touch the CSR (side-effect free read).
            OP_CSRRS: begin
                wdata    = old | src;
                do_write = |src;
            end
            OP_CSRRC: begin
                wdata    = old & ~src;
                do_write = |src;
            end
            default: begin
                wdata    = old;
                do_write = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/csr_seq_ctrl.sv
// Multi-cycle sequencer issuing ordered single-port CSR accesses for CSR ops, ECALL and MRET.
module csr_seq_ctrl
    import csr_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] TRAP_MSTATUS = 'h1800
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_op,
    input  logic [11:0]        in_csr_addr,
    input  logic [WIDTH-1:0]   in_src,
    input  logic [WIDTH-1:0]   in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_rdata,
    output logic               out_illegal,
    output logic               redirect_valid,
    output logic [WIDTH-1:0]   redirect_pc,
    output logic [11:0]        csr_addr,
    output logic               csr_wen,
    output logic [WIDTH-1:0]   csr_wdata,
    input  logic [WIDTH-1:0]   csr_rdata
);

    seq_state_e       state;
    csr_op_e          op_q;
    logic [11:0]      addr_q;
    logic [WIDTH-1:0] src_q;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] old_q;
    logic [WIDTH-1:0] redir_q;
    logic             illegal_q;

    logic [WIDTH-1:0] alu_wdata;
    logic             alu_wen;

    csr_rmw_alu #(.WIDTH(WIDTH)) u_alu (
        .op       (op_q),
        .old      (old_q),
        .src      (src_q),
        .wdata    (alu_wdata),
        .do_write (alu_wen)
    );

    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            op_q      <= OP_NOP;
            addr_q    <= '0;
            src_q     <= '0;
            pc_q      <= '0;
            old_q     <= '0;
            redir_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        // Illegal codes are stored as NOP so they never reach the ALU or redirect.
                        op_q      <= (in_op >= 3'd6) ? OP_NOP : csr_op_e'(in_op);
                        addr_q    <= in_csr_addr;
                        src_q     <= in_src;
                        pc_q      <= in_pc;
                        old_q     <= '0;
                        redir_q   <= '0;
                        illegal_q <= (in_op >= 3'd6);
                        case (in_op)
                            3'd1, 3'd2, 3'd3: state <= ST_RD;
                            3'd4:             state <= ST_EPC;
                            3'd5:             state <= ST_MRD;
                            default:          state <= ST_DONE;
                        endcase
                    end
                end
                ST_RD: begin
                    old_q <= csr_rdata;
                    state <= ST_WR;
                end
                ST_WR:    state <= ST_DONE;
                ST_EPC:   state <= ST_CAUSE;
                ST_CAUSE: state <= ST_STAT;
                ST_STAT:  state <= ST_VEC;
                ST_VEC: begin
                    redir_q <= csr_rdata & ~WIDTH'(3);
                    state   <= ST_DONE;
                end
                ST_MRD: begin
                    redir_q <= csr_rdata;
                    state   <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // CSR port is a pure decode of state, so reset silences it immediately.
    always_comb begin
        csr_addr  = '0;
        csr_wen   = 1'b0;
        csr_wdata = '0;
        case (state)
            ST_RD: csr_addr = addr_q;
            ST_WR: begin
                csr_addr  = addr_q;
                csr_wen   = alu_wen;
                csr_wdata = alu_wdata;
            end
            ST_EPC: begin
                csr_addr  = CSR_MEPC;
                csr_wen   = 1'b1;
                csr_wdata = pc_q;
            end
            ST_CAUSE: begin
                csr_addr  = CSR_MCAUSE;
                csr_wen   = 1'b1;
                csr_wdata = WIDTH'(MCAUSE_ECALL_M);
            end
            ST_STAT: begin
                csr_addr  = CSR_MSTATUS;
                csr_wen   = 1'b1;
                csr_wdata = TRAP_MSTATUS;
            end
            ST_VEC:  csr_addr = CSR_MTVEC;
            ST_MRD:  csr_addr = CSR_MEPC;
            default: begin
                csr_addr  = '0;
                csr_wen   = 1'b0;
                csr_wdata = '0;
            end
        endcase
    end

    assign in_ready       = (state == ST_IDLE);
    assign out_valid      = (state == ST_DONE);
    assign out_rdata      = old_q;
    assign out_illegal    = illegal_q;
    assign redirect_valid = out_valid && ((op_q == OP_ECALL) || (op_q == OP_MRET));
    assign redirect_pc    = redir_q;

endmodule

// File: tb/tb_csr_seq_ctrl.sv
// Directed self-checking bench for csr_seq_ctrl with a behavioural CSR read port and write log.
module tb_csr_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = 3'd0;
    logic [11:0] in_csr_addr = 12'h0;
    logic [31:0] in_src = 32'h0;
    logic [31:0] in_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_rdata;
    logic        out_illegal;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [11:0] csr_addr;
    logic        csr_wen;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;

    logic [31:0] rd_mstatus = 32'h0;
    logic [31:0] rd_mtvec   = 32'h0;
    logic [31:0] rd_mepc    = 32'h0;
    logic [31:0] rd_other   = 32'h0;

    logic [11:0] log_addr[$];
    logic [31:0] log_data[$];

    int checks = 0;
    int errors = 0;

    csr_seq_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_op          (in_op),
        .in_csr_addr    (in_csr_addr),
        .in_src         (in_src),
        .in_pc          (in_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_rdata      (out_rdata),
        .out_illegal    (out_illegal),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .csr_addr       (csr_addr),
        .csr_wen        (csr_wen),
        .csr_wdata      (csr_wdata),
        .csr_rdata      (csr_rdata)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (csr_addr)
            12'h300: csr_rdata = rd_mstatus;
            12'h305: csr_rdata = rd_mtvec;
            12'h341: csr_rdata = rd_mepc;
            default: csr_rdata = rd_other;
        endcase
    end

    always @(posedge clk) begin
        if (csr_wen) begin
            log_addr.push_back(csr_addr);
            log_data.push_back(csr_wdata);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one op, returns #1 after the accepting edge (cycle 1), then scrambles in_*.
    task automatic do_accept(input logic [2:0] op, input logic [11:0] addr,
                             input logic [31:0] src, input logic [31:0] pc);
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_csr_addr = addr; in_src = src; in_pc = pc;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL accept_ready got %b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_op = 3'd6; in_csr_addr = 12'hFFF; in_src = 32'hFFFF_FFFF; in_pc = 32'hFFFF_FFFF;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({in_ready, out_valid, redirect_valid, csr_wen, out_illegal} !== 5'b10000) begin
            errors++; $display("FAIL reset_flags got %b want 10000",
                               {in_ready, out_valid, redirect_valid, csr_wen, out_illegal});
        end
        checks++;
        if ({out_rdata, redirect_pc, csr_addr, csr_wdata} !== 108'h0) begin
            errors++; $display("FAIL reset_data got %h want 0", {out_rdata, redirect_pc, csr_addr, csr_wdata});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_csrrw();
        int n0;
        n0 = log_addr.size();
        rd_mtvec = 32'h0;
        do_accept(3'd1, 12'h305, 32'h8000_0100, 32'h0);
        checks++;
        if ({in_ready, out_valid, csr_wen, csr_addr} !== {1'b0, 1'b0, 1'b0, 12'h305}) begin
            errors++; $display("FAIL rw_c1 got %h want %h", {in_ready, out_valid, csr_wen, csr_addr}, {3'b000, 12'h305});
        end
        step();
        checks++;
        if ({csr_wen, csr_addr, csr_wdata} !== {1'b1, 12'h305, 32'h8000_0100}) begin
            errors++; $display("FAIL rw_c2 got %h want %h", {csr_wen, csr_addr, csr_wdata}, {1'b1, 12'h305, 32'h8000_0100});
        end
        step();
        checks++;
        if ({out_valid, redirect_valid, out_illegal, csr_wen, csr_addr, out_rdata} !== {4'b1000, 12'h0, 32'h0}) begin
            errors++; $display("FAIL rw_c3 got %h want %h",
                               {out_valid, redirect_valid, out_illegal, csr_wen, csr_addr, out_rdata}, {4'b1000, 44'h0});
        end
        step();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++; $display("FAIL rw_c4 got %b want 01", {out_valid, in_ready});
        end
        checks++;
        if (log_addr.size() != n0 + 1) begin
            errors++; $display("FAIL rw_write_count got %0d want %0d", log_addr.size() - n0, 1);
        end
    endtask

    task automatic test_csrrs();
        int n0;
        rd_mstatus = 32'h1800;
        do_accept(3'd2, 12'h300, 32'h8, 32'h0);
        step();
        checks++;
        if ({csr_wen, csr_addr, csr_wdata} !== {1'b1, 12'h300, 32'h1808}) begin
            errors++; $display("FAIL rs_wdata got %h want %h", {csr_wen, csr_addr, csr_wdata}, {1'b1, 12'h300, 32'h1808});
        end
        step();
        checks++;
        if ({out_valid, out_rdata} !== {1'b1, 32'h1800}) begin
            errors++; $display("FAIL rs_rdata got %h want %h", {out_valid, out_rdata}, {1'b1, 32'h1800});
        end
        step();
        n0 = log_addr.size();
        do_accept(3'd2, 12'h300, 32'h0, 32'h0);
        step();
        checks++;
        if ({csr_wen, csr_addr} !== {1'b0, 12'h300}) begin
            errors++; $display("FAIL rs_zero_nowrite got %h want %h", {csr_wen, csr_addr}, {1'b0, 12'h300});
        end
        step();
        checks++;
        if ({out_valid, out_rdata} !== {1'b1, 32'h1800} || log_addr.size() != n0) begin
            errors++; $display("FAIL rs_zero_result got %h writes %0d want %h writes 0",
                               {out_valid, out_rdata}, log_addr.size() - n0, {1'b1, 32'h1800});
        end
        step();
    endtask

    task automatic test_csrrc();
        rd_other = 32'hFFFF_00FF;
        do_accept(3'd3, 12'h7C0, 32'h0000_0F0F, 32'h0);
        step();
        checks++;
        if ({csr_wen, csr_addr, csr_wdata} !== {1'b1, 12'h7C0, 32'hFFFF_00F0}) begin
            errors++; $display("FAIL rc_wdata got %h want %h", {csr_wen, csr_addr, csr_wdata}, {1'b1, 12'h7C0, 32'hFFFF_00F0});
        end
        step();
        checks++;
        if ({out_valid, out_rdata} !== {1'b1, 32'hFFFF_00FF}) begin
            errors++; $display("FAIL rc_rdata got %h want %h", {out_valid, out_rdata}, {1'b1, 32'hFFFF_00FF});
        end
        step();
    endtask

    task automatic test_ecall();
        int n0;
        n0 = log_addr.size();
        rd_mtvec = 32'h8000_0203;
        do_accept(3'd4, 12'h123, 32'h5555_5555, 32'h8000_0040);
        checks++;
        if ({csr_wen, csr_addr, csr_wdata} !== {1'b1, 12'h341, 32'h8000_0040}) begin
            errors++; $display("FAIL ecall_mepc got %h want %h", {csr_wen, csr_addr, csr_wdata}, {1'b1, 12'h341, 32'h8000_0040});
        end
        step();
        checks++;
        if ({csr_wen, csr_addr, csr_wdata} !== {1'b1, 12'h342, 32'd11}) begin
            errors++; $display("FAIL ecall_mcause got %h want %h", {csr_wen, csr_addr, csr_wdata}, {1'b1, 12'h342, 32'd11});
        end
        step();
        checks++;
        if ({csr_wen, csr_addr, csr_wdata} !== {1'b1, 12'h300, 32'h1800}) begin
            errors++; $display("FAIL ecall_mstatus got %h want %h", {csr_wen, csr_addr, csr_wdata}, {1'b1, 12'h300, 32'h1800});
        end
        step();
        checks++;
        if ({csr_wen, csr_addr, out_valid} !== {1'b0, 12'h305, 1'b0}) begin
            errors++; $display("FAIL ecall_vec got %h want %h", {csr_wen, csr_addr, out_valid}, {1'b0, 12'h305, 1'b0});
        end
        step();
        checks++;
        if ({out_valid, redirect_valid, redirect_pc, out_rdata} !== {2'b11, 32'h8000_0200, 32'h0}) begin
            errors++; $display("FAIL ecall_redirect got %h want %h",
                               {out_valid, redirect_valid, redirect_pc, out_rdata}, {2'b11, 32'h8000_0200, 32'h0});
        end
        checks++;
        if (log_addr.size() != n0 + 3 ||
            {log_addr[n0], log_addr[n0+1], log_addr[n0+2]} !== {12'h341, 12'h342, 12'h300}) begin
            errors++; $display("FAIL ecall_order got %0d writes want 3 in order 341 342 300", log_addr.size() - n0);
        end
        step();
    endtask

    task automatic test_mret();
        rd_mepc = 32'h8000_0044;
        do_accept(3'd5, 12'h0, 32'h0, 32'h0);
        checks++;
        if ({csr_wen, csr_addr, out_valid} !== {1'b0, 12'h341, 1'b0}) begin
            errors++; $display("FAIL mret_read got %h want %h", {csr_wen, csr_addr, out_valid}, {1'b0, 12'h341, 1'b0});
        end
        step();
        checks++;
        if ({out_valid, redirect_valid, redirect_pc, out_rdata} !== {2'b11, 32'h8000_0044, 32'h0}) begin
            errors++; $display("FAIL mret_redirect got %h want %h",
                               {out_valid, redirect_valid, redirect_pc, out_rdata}, {2'b11, 32'h8000_0044, 32'h0});
        end
        step();
    endtask

    task automatic test_stall_back_to_back();
        int n0;
        rd_mtvec = 32'h8000_0203;
        out_ready = 1'b0;
        do_accept(3'd1, 12'h305, 32'h1234_5678, 32'h0);
        step();
        step();
        n0 = log_addr.size();
        in_valid = 1'b1; in_op = 3'd4;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({out_valid, out_rdata, in_ready, csr_wen, redirect_valid} !== {1'b1, 32'h8000_0203, 3'b000}) begin
                errors++; $display("FAIL stall_hold[%0d] got %h want %h", i,
                                   {out_valid, out_rdata, in_ready, csr_wen, redirect_valid}, {1'b1, 32'h8000_0203, 3'b000});
            end
            if (i < 3) step();
        end
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b0;
        step();
        checks++;
        if ({out_valid, in_ready} !== 2'b01 || log_addr.size() != n0) begin
            errors++; $display("FAIL stall_release got %b writes %0d want 01 writes 0",
                               {out_valid, in_ready}, log_addr.size() - n0);
        end
        do_accept(3'd0, 12'h0, 32'h0, 32'h0);
        checks++;
        if ({out_valid, out_illegal, out_rdata} !== {2'b10, 32'h0}) begin
            errors++; $display("FAIL nop_b2b got %h want %h", {out_valid, out_illegal, out_rdata}, {2'b10, 32'h0});
        end
        step();
    endtask

    task automatic test_illegal();
        int n0;
        n0 = log_addr.size();
        do_accept(3'd7, 12'h305, 32'hFFFF_FFFF, 32'h0);
        checks++;
        if ({out_valid, out_illegal, redirect_valid, csr_wen, csr_addr, out_rdata} !== {4'b1100, 12'h0, 32'h0}) begin
            errors++; $display("FAIL illegal_c1 got %h want %h",
                               {out_valid, out_illegal, redirect_valid, csr_wen, csr_addr, out_rdata}, {4'b1100, 44'h0});
        end
        step();
        checks++;
        if ({out_valid, in_ready} !== 2'b01 || log_addr.size() != n0) begin
            errors++; $display("FAIL illegal_noaccess got %b writes %0d want 01 writes 0",
                               {out_valid, in_ready}, log_addr.size() - n0);
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        n0 = log_addr.size();
        do_accept(3'd4, 12'h0, 32'h0, 32'h8000_0080);
        step();
        checks++;
        if ({csr_wen, csr_addr} !== {1'b1, 12'h342}) begin
            errors++; $display("FAIL rstmid_cause got %h want %h", {csr_wen, csr_addr}, {1'b1, 12'h342});
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({csr_wen, in_ready, out_valid, redirect_valid, csr_addr} !== {4'b0100, 12'h0}) begin
            errors++; $display("FAIL rstmid_abort got %h want %h",
                               {csr_wen, in_ready, out_valid, redirect_valid, csr_addr}, {4'b0100, 12'h0});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();
        checks++;
        if ({csr_wen, in_ready} !== 2'b01 || log_addr.size() != n0 + 1 || log_addr[n0] !== 12'h341) begin
            errors++; $display("FAIL rstmid_writes got %0d writes wen %b want 1 write (341) wen 0",
                               log_addr.size() - n0, csr_wen);
        end
    endtask

    initial begin
        test_reset();
        test_csrrw();
        test_csrrs();
        test_csrrc();
        test_ecall();
        test_mret();
        test_stall_back_to_back();
        test_illegal();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
